// File: rtl/mem_arbiter_n.sv
// Round-robin arbiter: NUM_PORTS cache requesters share one memory port.
// Ports: req_* per requester, grant/resp_* back, mem_* to the controller.
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int BLOCK_W   = 512,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS*BLOCK_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [NUM_PORTS-1:0]         resp_valid,
  output logic                         resp_err,
  output logic [BLOCK_W-1:0]           resp_data,
  output logic                         busy,
  output logic                         mem_req,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [BLOCK_W-1:0]           mem_wdata,
  input  logic [BLOCK_W-1:0]           mem_data_in,
  input  logic                         mem_data_valid
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [BLOCK_W-1:0]   resp_data_q, resp_data_d;
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic                 cnt_hit;
  logic [PTR_W-1:0]     owner_nxt;

  // First requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(j);
      end
    end
  end

  // Timeout fires on the TIMEOUT-th ISSUE cycle; disabled when 0.
  assign cnt_hit   = (TIMEOUT > 0) && ((int'(cnt_q) + 1) == TIMEOUT);
  assign owner_nxt = (int'(owner_q) == NUM_PORTS - 1) ?
                     '0 : PTR_W'(owner_q + 1'b1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    resp_valid_d = '0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_ISSUE;
          owner_d     = pick_idx;
          cnt_d       = '0;
          grant_d     = NUM_PORTS'(1) << pick_idx;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          mem_wr_en_d = req_wr[pick_idx];
          mem_addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[int'(pick_idx)*BLOCK_W +: BLOCK_W];
        end
      end
      S_ISSUE: begin
        if (mem_data_valid) begin
          state_d      = S_DONE;
          resp_data_d  = mem_data_in;
          resp_err_d   = 1'b0;
          resp_valid_d = grant_q;
          mem_req_d    = 1'b0;
        end else if (cnt_hit) begin
          state_d      = S_DONE;
          resp_err_d   = 1'b1;
          resp_valid_d = grant_q;
          mem_req_d    = 1'b0;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = owner_nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign grant      = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: 2 ports, TIMEOUT=8.
// Inputs change 1 time unit after each rising edge; checks follow.
module tb_mem_arbiter_n;

  localparam int NP = 2;
  localparam int AW = 64;
  localparam int BW = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_wr;
  logic [NP*AW-1:0] req_addr;
  logic [NP*BW-1:0] req_wdata;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   resp_valid;
  logic            resp_err;
  logic [BW-1:0]   resp_data;
  logic            busy;
  logic            mem_req;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [BW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_data_in;
  logic            mem_data_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] d_a5, d_wr, d_to, d_ff, d_ab;
  logic [NP-1:0] exp_g;

  always #5 clk = ~clk;

  mem_arbiter_n #(
    .NUM_PORTS(NP), .ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_data(resp_data),
    .busy(busy), .mem_req(mem_req),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d_a5 = {64{8'hA5}};
    d_wr = {16{32'hDEADBEEF}};
    d_to = {16{32'h0BADF00D}};
    d_ff = {64{8'hFF}};
    d_ab = {16{32'h13579BDF}};
    rst = 1'b1;
    req_valid = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_data_in = '0;
    mem_data_valid = 1'b0;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    step();

    // single read from port 0
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h1000;
    step();
    chk("rd_grant", grant, 2'b01);
    chk("rd_mem_req", mem_req, 1);
    chk("rd_addr", mem_addr, 64'h1000);
    chk("rd_wr_en", mem_wr_en, 0);
    chk("rd_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rd_wait_req", mem_req, 1);
      chk("rd_wait_rv", resp_valid, 0);
    end
    mem_data_valid = 1'b1;
    mem_data_in = d_a5;
    step();
    mem_data_valid = 1'b0;
    chk("rd_resp_valid", resp_valid, 2'b01);
    chk("rd_resp_data", resp_data, d_a5);
    chk("rd_resp_err", resp_err, 0);
    chk("rd_done_req", mem_req, 0);
    req_valid = 2'b00;
    step();
    chk("rd_idle_rv", resp_valid, 0);
    chk("rd_idle_grant", grant, 0);
    chk("rd_idle_busy", busy, 0);

    // contention from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      step();
      chk("ct_grant", grant, exp_g);
      step();
      mem_data_valid = 1'b1;
      mem_data_in = BW'(t + 1);
      step();
      mem_data_valid = 1'b0;
      chk("ct_resp_valid", resp_valid, exp_g);
      chk("ct_resp_data", resp_data, BW'(t + 1));
      step();
      chk("ct_idle_grant", grant, 0);
    end
    req_valid = 2'b00;

    // write from port 1
    req_valid = 2'b10;
    req_wr = 2'b10;
    req_addr[AW +: AW] = 64'h2040;
    req_wdata[BW +: BW] = BW'(16'h1234);
    step();
    chk("wr_grant", grant, 2'b10);
    chk("wr_en", mem_wr_en, 1);
    chk("wr_addr", mem_addr, 64'h2040);
    chk("wr_wdata", mem_wdata, BW'(16'h1234));
    req_addr[AW +: AW] = 64'hFFFF;
    req_wdata[BW +: BW] = '0;
    req_wr = 2'b00;
    step();
    step();
    chk("wr_hold_en", mem_wr_en, 1);
    chk("wr_hold_addr", mem_addr, 64'h2040);
    chk("wr_hold_wdata", mem_wdata, BW'(16'h1234));
    mem_data_valid = 1'b1;
    mem_data_in = d_wr;
    step();
    mem_data_valid = 1'b0;
    chk("wr_resp_valid", resp_valid, 2'b10);
    req_valid = 2'b00;
    step();

    // timeout: port 0, memory silent for 8 ISSUE cycles
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h3000;
    step();
    chk("to_grant", grant, 2'b01);
    for (int k = 0; k < 7; k++) step();
    chk("to_cycle8_req", mem_req, 1);
    chk("to_cycle8_rv", resp_valid, 0);
    step();
    chk("to_resp_valid", resp_valid, 2'b01);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_data", resp_data, d_wr);
    chk("to_mem_req", mem_req, 0);
    req_valid = 2'b00;
    step();
    chk("to_idle_grant", grant, 0);
    chk("to_idle_busy", busy, 0);

    // mem_data_valid on the 8th cycle beats the timeout
    req_valid = 2'b10;
    step();
    chk("tie_grant", grant, 2'b10);
    for (int k = 0; k < 7; k++) step();
    mem_data_valid = 1'b1;
    mem_data_in = d_to;
    step();
    mem_data_valid = 1'b0;
    chk("tie_resp_valid", resp_valid, 2'b10);
    chk("tie_resp_err", resp_err, 0);
    chk("tie_resp_data", resp_data, d_to);
    req_valid = 2'b00;
    step();

    // reset two cycles into ISSUE, then stray response
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h4000;
    req_wr = 2'b01;
    step();
    step();
    step();
    chk("mr_mem_req", mem_req, 1);
    rst = 1'b1;
    #2;
    chk("mr_async_req", mem_req, 0);
    chk("mr_async_grant", grant, 0);
    chk("mr_async_busy", busy, 0);
    chk("mr_async_addr", mem_addr, 0);
    chk("mr_async_wr", mem_wr_en, 0);
    chk("mr_async_err", resp_err, 0);
    chk("mr_async_data", resp_data, 0);
    req_valid = 2'b00;
    req_wr = 2'b00;
    step();
    chk("mr_rst_rv", resp_valid, 0);
    rst = 1'b0;
    mem_data_valid = 1'b1;
    mem_data_in = d_ff;
    step();
    mem_data_valid = 1'b0;
    chk("stray_rv", resp_valid, 0);
    chk("stray_data", resp_data, 0);
    chk("stray_busy", busy, 0);
    chk("stray_req", mem_req, 0);
    step();
    chk("stray_rv2", resp_valid, 0);
    chk("stray_grant", grant, 0);

    // port 0 abandons its request during ISSUE
    req_valid = 2'b01;
    req_addr[0 +: AW] = 64'h5000;
    step();
    chk("ab_grant", grant, 2'b01);
    req_valid = 2'b00;
    step();
    chk("ab_req", mem_req, 1);
    mem_data_valid = 1'b1;
    mem_data_in = d_ab;
    step();
    mem_data_valid = 1'b0;
    chk("ab_resp_valid", resp_valid, 2'b01);
    chk("ab_resp_data", resp_data, d_ab);
    step();
    chk("ab_idle_rv", resp_valid, 0);
    chk("ab_idle_grant", grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL provide parameter NUM_PORTS, default 2: number of cache-side requesters; legal range 1..8.
REQ-002 SHALL provide parameter ADDR_W, default 64: request address width.
REQ-003 SHALL provide parameter BLOCK_W, default 512: cache-line data width.
REQ-004 SHALL provide parameter TIMEOUT, default 1023: maximum BUSY cycles before abort; 0 disables the timeout.
REQ-005 SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request; held high until that port's resp_valid
- req_wr  in  NUM_PORTS  per-port write (1) / read (0)
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*BLOCK_W  per-port write line
- grant  out  NUM_PORTS  one-hot owner of the current transaction; zero when idle
- resp_valid  out  NUM_PORTS  one-cycle completion pulse to the owner
- resp_err  out  1  qualifies resp_valid: transaction timed out
- resp_data  out  BLOCK_W  read line; valid with resp_valid
- busy  out  1  high in ISSUE and DONE
- mem_req  out  1  request to the memory controller
- mem_wr_en  out  1  latched req_wr of the owner
- mem_addr  out  ADDR_W  latched address of the owner
- mem_wdata  out  BLOCK_W  latched write line of the owner
- mem_data_in  in  BLOCK_W  line returned by the memory controller
- mem_data_valid  in  1  memory completion, single-cycle pulse

Function
REQ-006 SHALL implement a three-state FSM: IDLE, ISSUE, DONE.
REQ-007 In IDLE with any req_valid set, the block SHALL select the first set port scanning upward from rr_ptr with wrap-around.
- Same edge: latch that port's addr, wr and wdata; set grant; enter ISSUE.
REQ-008 mem_req SHALL be high for every ISSUE cycle; mem_addr, mem_wr_en and mem_wdata SHALL stay stable throughout ISSUE.
REQ-009 Latency: req_valid sampled in IDLE at edge N SHALL give mem_req high from cycle N+1.
REQ-010 On mem_data_valid in ISSUE, the block SHALL capture mem_data_in into resp_data, clear resp_err, and enter DONE.
- For writes, resp_data SHALL still be captured; its contents are don't-care.
REQ-011 In DONE, resp_valid[owner] SHALL be high for exactly one cycle; mem_req SHALL be low.
- Next edge: grant cleared, rr_ptr set to (owner+1) mod NUM_PORTS, state returns to IDLE.
REQ-012 Round-robin ordering SHALL guarantee that no continuously requesting port waits more than NUM_PORTS-1 transactions.
REQ-013 A requester dropping req_valid during ISSUE SHALL NOT abort the transaction; it still completes and pulses resp_valid.
REQ-014 mem_data_valid in IDLE or DONE SHALL be ignored, with no state or output change.
REQ-015 With TIMEOUT>0, a cycle counter SHALL clear on ISSUE entry and increment each ISSUE cycle.
- On reaching TIMEOUT without mem_data_valid: enter DONE with resp_err=1 and resp_data unchanged.
- If mem_data_valid arrives in the same cycle the counter reaches TIMEOUT, mem_data_valid SHALL win (resp_err=0).
REQ-016 Requests arriving in ISSUE or DONE SHALL wait; an IDLE cycle always separates consecutive transactions.
REQ-017 With NUM_PORTS=1, rr_ptr SHALL be a constant 0 and behaviour SHALL otherwise be identical.
REQ-018 rr_ptr width SHALL be max(1, clog2(NUM_PORTS)); the increment SHALL wrap to 0 after NUM_PORTS-1.

Reset
REQ-019 Asserting rst SHALL immediately, without a clock edge, force:
- state IDLE, rr_ptr 0, counter 0
- grant 0, resp_valid 0, resp_err 0, resp_data 0, busy 0
- mem_req 0, mem_wr_en 0, mem_addr 0, mem_wdata 0
REQ-020 Reset asserted mid-transaction SHALL drop mem_req at once and discard the transaction with no resp_valid.
- After reset releases, the block SHALL resume in IDLE; a later stray mem_data_valid SHALL be ignored per REQ-014.

Verification
REQ-021 Single read:
- Stimulus: NUM_PORTS=2; port0 reads addr 0x1000; mem_data_valid 5 cycles after mem_req rises with data 0xA5..A5.
- Response: mem_req rises 1 cycle after req_valid; resp_valid[0] pulses 1 cycle after mem_data_valid; resp_data=0xA5..A5; resp_err=0.
REQ-022 Contention:
- Stimulus: ports 0 and 1 request continuously from reset.
- Response: grant sequence 01,10,01,10; no port starved.
REQ-023 Write:
- Stimulus: port1 writes addr 0x2040, wdata 0x1234.
- Response: mem_wr_en=1, mem_addr=0x2040, mem_wdata=0x1234 held stable until mem_data_valid; then resp_valid[1] pulses.
REQ-024 Timeout:
- Stimulus: TIMEOUT=8; memory never responds.
- Response: after 8 ISSUE cycles, resp_valid pulses with resp_err=1; mem_req drops; block returns to IDLE.
REQ-025 Reset mid-operation:
- Stimulus: rst pulsed 2 cycles into ISSUE; mem_data_valid arrives afterwards.
- Response: all outputs 0 asynchronously; no resp_valid at any point.
REQ-026 Stray response and requester abandonment:
- Stimulus: mem_data_valid while IDLE; separately, port0 drops req_valid during ISSUE.
- Response: stray pulse produces no output change; abandoned transaction still completes with resp_valid[0].
